// File: rtl/crtc_6845.sv
// crtc_6845: character CRT timing generator with an MC6845-subset register file.
// Video outputs are registered decodes of the counter state and lag it by one character.
module crtc_6845 (
    input  logic        PIXELCLK,
    input  logic        nRESET,
    input  logic        CHAR_EN,
    input  logic        PROC_EN,
    input  logic        nCS,
    input  logic        RnW,
    input  logic        A0,
    input  logic [7:0]  pDATA,
    output logic [7:0]  pDATA_out,
    output logic [13:0] MA,
    output logic [4:0]  RA,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DISEN,
    output logic        CURSOR
);

    // state    | meaning
    // V_ROWS   | counting character rows 0..R4
    // V_ADJUST | extra scanlines after the last row, before frame end
    typedef enum logic {V_ROWS, V_ADJUST} vstate_e;

    vstate_e     vstate_q, vstate_d;
    logic [7:0]  r_htotal_q, r_htotal_d, r_hdisp_q, r_hdisp_d;
    logic [7:0]  r_hsync_pos_q, r_hsync_pos_d, r_sync_w_q, r_sync_w_d;
    logic [6:0]  r_vtotal_q, r_vtotal_d, r_vdisp_q, r_vdisp_d;
    logic [6:0]  r_vsync_pos_q, r_vsync_pos_d, r_cur_start_q, r_cur_start_d;
    logic [4:0]  r_vadj_q, r_vadj_d, r_max_ra_q, r_max_ra_d, r_cur_end_q, r_cur_end_d;
    logic [5:0]  r_start_hi_q, r_start_hi_d, r_cur_hi_q, r_cur_hi_d;
    logic [7:0]  r_start_lo_q, r_start_lo_d, r_cur_lo_q, r_cur_lo_d;
    logic [4:0]  ar_q, ar_d;
    logic [7:0]  pdata_q, pdata_d;

    logic [7:0]  hc_q, hc_d;
    logic [4:0]  ra_q, ra_d;
    logic [6:0]  vc_q, vc_d;
    logic [4:0]  fc_q, fc_d;
    logic [13:0] ma_row_q, ma_row_d;
    logic [3:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    logic [13:0] ma_q, ma_d;
    logic [4:0]  ra_out_q, ra_out_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, disen_q, disen_d, cursor_q, cursor_d;

    logic        wr_en, rd_en;
    logic        eol, row_end, adj_end, in_adj, frame_end;
    logic        hs_start, vs_start, hsync_now, vsync_now, disen_now, cursor_now, blink_on;
    logic [3:0]  hsync_w, vsync_w;
    logic [13:0] ma_now;

    assign wr_en = PROC_EN && !nCS && !RnW;
    assign rd_en = PROC_EN && !nCS && RnW && A0;

    always_comb begin
        r_htotal_d    = r_htotal_q;
        r_hdisp_d     = r_hdisp_q;
        r_hsync_pos_d = r_hsync_pos_q;
        r_sync_w_d    = r_sync_w_q;
        r_vtotal_d    = r_vtotal_q;
        r_vadj_d      = r_vadj_q;
        r_vdisp_d     = r_vdisp_q;
        r_vsync_pos_d = r_vsync_pos_q;
        r_max_ra_d    = r_max_ra_q;
        r_cur_start_d = r_cur_start_q;
        r_cur_end_d   = r_cur_end_q;
        r_start_hi_d  = r_start_hi_q;
        r_start_lo_d  = r_start_lo_q;
        r_cur_hi_d    = r_cur_hi_q;
        r_cur_lo_d    = r_cur_lo_q;
        ar_d          = ar_q;
        pdata_d       = pdata_q;
        if (wr_en && !A0) begin
            ar_d = pDATA[4:0];
        end
        // Addresses 16..31 select nothing; R8 is accepted but not stored.
        if (wr_en && A0 && !ar_q[4]) begin
            case (ar_q[3:0])
                4'd0:    r_htotal_d    = pDATA;
                4'd1:    r_hdisp_d     = pDATA;
                4'd2:    r_hsync_pos_d = pDATA;
                4'd3:    r_sync_w_d    = pDATA;
                4'd4:    r_vtotal_d    = pDATA[6:0];
                4'd5:    r_vadj_d      = pDATA[4:0];
                4'd6:    r_vdisp_d     = pDATA[6:0];
                4'd7:    r_vsync_pos_d = pDATA[6:0];
                4'd9:    r_max_ra_d    = pDATA[4:0];
                4'd10:   r_cur_start_d = pDATA[6:0];
                4'd11:   r_cur_end_d   = pDATA[4:0];
                4'd12:   r_start_hi_d  = pDATA[5:0];
                4'd13:   r_start_lo_d  = pDATA;
                4'd14:   r_cur_hi_d    = pDATA[5:0];
                4'd15:   r_cur_lo_d    = pDATA;
                default: ;
            endcase
        end
        if (rd_en) begin
            case (ar_q)
                5'd14:   pdata_d = {2'b00, r_cur_hi_q};
                5'd15:   pdata_d = r_cur_lo_q;
                default: pdata_d = 8'h00;
            endcase
        end
    end

    assign in_adj    = (vstate_q == V_ADJUST);
    assign eol       = (hc_q == r_htotal_q);
    assign row_end   = (ra_q == r_max_ra_q);
    assign adj_end   = ((ra_q + 5'd1) == r_vadj_q);
    assign hsync_w   = r_sync_w_q[3:0];
    assign vsync_w   = r_sync_w_q[7:4];
    assign hs_start  = (hc_q == r_hsync_pos_q) && (hsync_w != 4'd0);
    assign hsync_now = hs_start || (h_cnt_q != 4'd0);
    assign vs_start  = !in_adj && (vc_q == r_vsync_pos_q) && (ra_q == 5'd0);
    assign vsync_now = vs_start || (v_cnt_q != 4'd0);
    assign ma_now    = ma_row_q + {6'd0, hc_q};
    assign disen_now = (hc_q < r_hdisp_q) && (vc_q < r_vdisp_q) && !in_adj;

    always_comb begin
        blink_on = 1'b1;
        case (r_cur_start_q[6:5])
            2'b00:   blink_on = 1'b1;
            2'b01:   blink_on = 1'b0;
            2'b10:   blink_on = fc_q[3];
            default: blink_on = fc_q[4];
        endcase
    end

    assign cursor_now = (ma_now == {r_cur_hi_q, r_cur_lo_q}) && (ra_q >= r_cur_start_q[4:0])
                        && (ra_q <= r_cur_end_q) && disen_now && blink_on;

    always_comb begin
        vstate_d  = vstate_q;
        hc_d      = hc_q;
        ra_d      = ra_q;
        vc_d      = vc_q;
        fc_d      = fc_q;
        ma_row_d  = ma_row_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        ma_d      = ma_q;
        ra_out_d  = ra_out_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        disen_d   = disen_q;
        cursor_d  = cursor_q;
        frame_end = 1'b0;
        if (CHAR_EN) begin
            ma_d     = ma_now;
            ra_out_d = ra_q;
            hsync_d  = hsync_now;
            vsync_d  = vsync_now;
            disen_d  = disen_now;
            cursor_d = cursor_now;
            hc_d     = eol ? 8'd0 : hc_q + 8'd1;
            if (hs_start) begin
                h_cnt_d = hsync_w - 4'd1;
            end else if (h_cnt_q != 4'd0) begin
                h_cnt_d = h_cnt_q - 4'd1;
            end
            if (eol) begin
                // A zero vertical width wraps to 15 remaining lines, i.e. 16 in total.
                if (vs_start) begin
                    v_cnt_d = vsync_w - 4'd1;
                end else if (v_cnt_q != 4'd0) begin
                    v_cnt_d = v_cnt_q - 4'd1;
                end
                case (vstate_q)
                    V_ROWS: begin
                        if (row_end) begin
                            ma_row_d = ma_row_q + {6'd0, r_hdisp_q};
                            ra_d     = 5'd0;
                            if (vc_q == r_vtotal_q) begin
                                if (r_vadj_q == 5'd0) frame_end = 1'b1;
                                else                  vstate_d  = V_ADJUST;
                            end else begin
                                vc_d = vc_q + 7'd1;
                            end
                        end else begin
                            ra_d = ra_q + 5'd1;
                        end
                    end
                    default: begin
                        if (adj_end) frame_end = 1'b1;
                        else         ra_d      = ra_q + 5'd1;
                    end
                endcase
                if (frame_end) begin
                    vstate_d = V_ROWS;
                    vc_d     = 7'd0;
                    ra_d     = 5'd0;
                    fc_d     = fc_q + 5'd1;
                    ma_row_d = {r_start_hi_q, r_start_lo_q};
                end
            end
        end
    end

    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            vstate_q      <= V_ROWS;
            r_htotal_q    <= '0;
            r_hdisp_q     <= '0;
            r_hsync_pos_q <= '0;
            r_sync_w_q    <= '0;
            r_vtotal_q    <= '0;
            r_vadj_q      <= '0;
            r_vdisp_q     <= '0;
            r_vsync_pos_q <= '0;
            r_max_ra_q    <= '0;
            r_cur_start_q <= '0;
            r_cur_end_q   <= '0;
            r_start_hi_q  <= '0;
            r_start_lo_q  <= '0;
            r_cur_hi_q    <= '0;
            r_cur_lo_q    <= '0;
            ar_q          <= '0;
            pdata_q       <= '0;
            hc_q          <= '0;
            ra_q          <= '0;
            vc_q          <= '0;
            fc_q          <= '0;
            ma_row_q      <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            ma_q          <= '0;
            ra_out_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            disen_q       <= 1'b0;
            cursor_q      <= 1'b0;
        end else begin
            vstate_q      <= vstate_d;
            r_htotal_q    <= r_htotal_d;
            r_hdisp_q     <= r_hdisp_d;
            r_hsync_pos_q <= r_hsync_pos_d;
            r_sync_w_q    <= r_sync_w_d;
            r_vtotal_q    <= r_vtotal_d;
            r_vadj_q      <= r_vadj_d;
            r_vdisp_q     <= r_vdisp_d;
            r_vsync_pos_q <= r_vsync_pos_d;
            r_max_ra_q    <= r_max_ra_d;
            r_cur_start_q <= r_cur_start_d;
            r_cur_end_q   <= r_cur_end_d;
            r_start_hi_q  <= r_start_hi_d;
            r_start_lo_q  <= r_start_lo_d;
            r_cur_hi_q    <= r_cur_hi_d;
            r_cur_lo_q    <= r_cur_lo_d;
            ar_q          <= ar_d;
            pdata_q       <= pdata_d;
            hc_q          <= hc_d;
            ra_q          <= ra_d;
            vc_q          <= vc_d;
            fc_q          <= fc_d;
            ma_row_q      <= ma_row_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            ma_q          <= ma_d;
            ra_out_q      <= ra_out_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disen_q       <= disen_d;
            cursor_q      <= cursor_d;
        end
    end

    assign pDATA_out = pdata_q;
    assign MA        = ma_q;
    assign RA        = ra_out_q;
    assign HSYNC     = hsync_q;
    assign VSYNC     = vsync_q;
    assign DISEN     = disen_q;
    assign CURSOR    = cursor_q;

endmodule

// File: tb/tb_crtc_6845.sv
// tb_crtc_6845: directed stimulus with a cycle-level behavioural model of the CRTC,
// plus literal expectations on captured traces that pin the model.
module tb_crtc_6845;
    logic        clk = 1'b0;
    logic        nres, char_en, proc_en, ncs, rnw, a0;
    logic [7:0]  pdata, pdata_out;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        hsync, vsync, disen, cursor;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crtc_6845 dut (
        .PIXELCLK(clk), .nRESET(nres), .CHAR_EN(char_en), .PROC_EN(proc_en),
        .nCS(ncs), .RnW(rnw), .A0(a0), .pDATA(pdata), .pDATA_out(pdata_out),
        .MA(ma), .RA(ra), .HSYNC(hsync), .VSYNC(vsync), .DISEN(disen), .CURSOR(cursor)
    );

    // ---------------- behavioural model ----------------
    int mreg [0:15];
    int mask [0:15] = '{255, 255, 255, 255, 127, 31, 127, 127, 0, 31, 127, 31, 63, 255, 63, 255};
    int mar;
    int m_hc, m_ra, m_vc, m_fc, m_ma_row, m_adj;
    int h_age, v_age;   // characters since HSYNC start position / scanlines since VSYNC start line
    int e_ma, e_ra, e_hs, e_vs, e_de, e_cu, e_pd;

    task automatic frame_end();
        m_vc = 0; m_ra = 0; m_adj = 0;
        m_fc = (m_fc + 1) % 32;
        m_ma_row = mreg[12] * 256 + mreg[13];
    endtask

    task automatic next_line();
        if (m_adj != 0) begin
            if ((m_ra + 1) % 32 == mreg[5]) frame_end();
            else m_ra = (m_ra + 1) % 32;
        end else if (m_ra == mreg[9]) begin
            m_ma_row = (m_ma_row + mreg[1]) % 16384;
            if (m_vc == mreg[4]) begin
                if (mreg[5] == 0) frame_end();
                else begin m_adj = 1; m_ra = 0; end
            end else begin
                m_vc = (m_vc + 1) % 128; m_ra = 0;
            end
        end else begin
            m_ra = (m_ra + 1) % 32;
        end
    endtask

    task automatic model_char();
        int hw, vw, v_cur, blink;
        hw = mreg[3] % 16;
        vw = mreg[3] / 16;
        if (vw == 0) vw = 16;
        h_age = (m_hc == mreg[2]) ? 0 : ((h_age < 1000) ? h_age + 1 : 1000);
        v_cur = (m_adj == 0 && m_vc == mreg[7] && m_ra == 0) ? 0 : v_age;
        e_hs = (hw != 0 && h_age < hw) ? 1 : 0;
        e_vs = (v_cur < vw) ? 1 : 0;
        e_ma = (m_ma_row + m_hc) % 16384;
        e_ra = m_ra;
        e_de = (m_hc < mreg[1] && m_vc < mreg[6] && m_adj == 0) ? 1 : 0;
        case (mreg[10] / 32)
            0: blink = 1;
            1: blink = 0;
            2: blink = (m_fc / 8) % 2;
            default: blink = (m_fc / 16) % 2;
        endcase
        e_cu = (e_de == 1 && e_ma == mreg[14] * 256 + mreg[15] && m_ra >= mreg[10] % 32
                && m_ra <= mreg[11] && blink == 1) ? 1 : 0;
        if (m_hc == mreg[0]) begin
            m_hc = 0;
            v_age = (v_cur < 1000) ? v_cur + 1 : 1000;
            next_line();
        end else begin
            m_hc = (m_hc + 1) % 256;
            v_age = v_cur;
        end
    endtask

    always @(posedge clk) begin
        if (!nres) begin
            for (int i = 0; i < 16; i++) mreg[i] = 0;
            mar = 0; m_hc = 0; m_ra = 0; m_vc = 0; m_fc = 0; m_ma_row = 0; m_adj = 0;
            h_age = 1000; v_age = 1000;
            e_ma = 0; e_ra = 0; e_hs = 0; e_vs = 0; e_de = 0; e_cu = 0; e_pd = 0;
        end else begin
            if (char_en) model_char();
            if (proc_en && !ncs) begin
                if (!rnw) begin
                    if (!a0) mar = int'(pdata) % 32;
                    else if (mar < 16) mreg[mar] = int'(pdata) & mask[mar];
                end else if (a0) begin
                    e_pd = (mar == 14) ? mreg[14] : ((mar == 15) ? mreg[15] : 0);
                end
            end
        end
    end

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if ({pdata_out, ma, ra, hsync, vsync, disen, cursor} !==
            {e_pd[7:0], e_ma[13:0], e_ra[4:0], e_hs[0], e_vs[0], e_de[0], e_cu[0]}) begin
            errors++;
            $display("FAIL cycle_model t=%0t got pd=%h ma=%h ra=%0d hs=%b vs=%b de=%b cu=%b required pd=%h ma=%h ra=%0d hs=%0d vs=%0d de=%0d cu=%0d",
                     $time, pdata_out, ma, ra, hsync, vsync, disen, cursor,
                     e_pd[7:0], e_ma[13:0], e_ra, e_hs, e_vs, e_de, e_cu);
        end
    end

    // ---------------- literal checks and traces ----------------
    localparam int S_MA = 0, S_RA = 1, S_HS = 2, S_VS = 3, S_DE = 4, S_CU = 5;
    int tr [0:5][0:2047];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int tsum(input int s, input int lo, input int n);
        int acc = 0;
        for (int i = lo; i < lo + n; i++) acc += tr[s][i];
        return acc;
    endfunction

    task automatic run(input int skip, input int n);
        char_en = 1'b1;
        for (int k = 0; k < skip + n; k++) begin
            @(negedge clk);
            if (k >= skip) begin
                tr[S_MA][k - skip] = int'(ma);
                tr[S_RA][k - skip] = int'(ra);
                tr[S_HS][k - skip] = int'(hsync);
                tr[S_VS][k - skip] = int'(vsync);
                tr[S_DE][k - skip] = int'(disen);
                tr[S_CU][k - skip] = int'(cursor);
            end
        end
        char_en = 1'b0;
    endtask

    task automatic set_ar(input int a);
        proc_en = 1'b1; ncs = 1'b0; rnw = 1'b0; a0 = 1'b0; pdata = 8'(a);
        @(negedge clk);
        proc_en = 1'b0; ncs = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        set_ar(a);
        proc_en = 1'b1; ncs = 1'b0; rnw = 1'b0; a0 = 1'b1; pdata = 8'(d);
        @(negedge clk);
        proc_en = 1'b0; ncs = 1'b1; a0 = 1'b0;
    endtask

    task automatic rd(output int v);
        proc_en = 1'b1; ncs = 1'b0; rnw = 1'b1; a0 = 1'b1;
        @(negedge clk);
        proc_en = 1'b0; ncs = 1'b1; rnw = 1'b0; a0 = 1'b0;
        v = int'(pdata_out);
    endtask

    task automatic prog(input int r [0:15]);
        for (int i = 0; i < 16; i++) if (i != 8) wr(i, r[i]);
    endtask

    task automatic do_reset();
        nres = 1'b0;
        @(negedge clk);
        nres = 1'b1;
    endtask

    int base [0:15];
    int cfg  [0:15];
    int v;

    initial begin
        nres = 1'b0; char_en = 1'b1; proc_en = 1'b0; ncs = 1'b1; rnw = 1'b0; a0 = 1'b0; pdata = 8'h00;
        base = '{63, 40, 49, 'h24, 2, 0, 2, 1, 0, 7, 'h02, 3, 0, 0, 0, 5};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", int'({pdata_out, ma, ra, hsync, vsync, disen, cursor}), 0);
        end
        nres = 1'b1;
        run(0, 20);
        chk("zero_regs_disen", tsum(S_DE, 0, 20), 0);
        chk("zero_regs_ma", tsum(S_MA, 0, 20), 0);
        chk("zero_regs_hsync", tsum(S_HS, 0, 20), 0);

        // Base geometry: 3 rows x 8 scanlines x 64 characters.
        do_reset();
        prog(base);
        run(0, 1600);
        chk("disen_line0_first", tr[S_DE][0], 1);
        chk("disen_line0_last", tr[S_DE][39], 1);
        chk("disen_line0_after", tr[S_DE][40], 0);
        chk("disen_row2", tr[S_DE][16 * 64], 0);
        chk("disen_frame_count", tsum(S_DE, 0, 1536), 640);
        chk("hsync_before", tr[S_HS][48], 0);
        chk("hsync_first", tr[S_HS][49], 1);
        chk("hsync_last", tr[S_HS][52], 1);
        chk("hsync_after", tr[S_HS][53], 0);
        chk("hsync_frame_count", tsum(S_HS, 0, 1536), 96);
        chk("vsync_before", tr[S_VS][511], 0);
        chk("vsync_first", tr[S_VS][512], 1);
        chk("vsync_last", tr[S_VS][639], 1);
        chk("vsync_after", tr[S_VS][640], 0);
        chk("vsync_frame_count", tsum(S_VS, 0, 1536), 128);
        chk("ma_row0_char39", tr[S_MA][7 * 64 + 39], 39);
        chk("ma_row1_start", tr[S_MA][8 * 64], 40);
        chk("ma_row1_char39", tr[S_MA][8 * 64 + 39], 79);
        chk("frame_last_ra", tr[S_RA][1535], 7);
        chk("frame_last_ma", tr[S_MA][1535], 143);
        chk("frame_restart_ma", tr[S_MA][1536], 0);
        chk("frame_restart_ra", tr[S_RA][1536], 0);
        chk("frame_restart_disen", tr[S_DE][1536], 1);
        chk("cursor_count", tsum(S_CU, 0, 1536), 2);
        chk("cursor_ra2", tr[S_CU][2 * 64 + 5], 1);
        chk("cursor_ra3", tr[S_CU][3 * 64 + 5], 1);
        chk("cursor_ra4", tr[S_CU][4 * 64 + 5], 0);

        // Start address near the top of the 14-bit space.
        do_reset();
        cfg = base; cfg[12] = 'h3F; cfg[13] = 'hF0;
        prog(cfg);
        run(1536, 9 * 64);
        chk("wrap_ma_top", tr[S_MA][15], 'h3FFF);
        chk("wrap_ma_zero", tr[S_MA][16], 0);
        chk("wrap_row1_start", tr[S_MA][8 * 64], 'h18);

        // Three adjust scanlines after the last row.
        do_reset();
        cfg = base; cfg[5] = 3;
        prog(cfg);
        run(0, 1792);
        chk("adj_ra0", tr[S_RA][24 * 64], 0);
        chk("adj_ra1", tr[S_RA][25 * 64], 1);
        chk("adj_ra2", tr[S_RA][26 * 64 + 10], 2);
        chk("adj_disen", tr[S_DE][24 * 64 + 3], 0);
        chk("adj_restart_ra", tr[S_RA][27 * 64], 0);
        chk("adj_restart_disen", tr[S_DE][27 * 64], 1);
        chk("adj_restart_ma", tr[S_MA][27 * 64], 0);

        // Register file access.
        do_reset();
        wr(14, 'h3A); rd(v); chk("read_r14", v, 'h3A);
        wr(14, 'hFF); rd(v); chk("read_r14_masked", v, 'h3F);
        wr(20, 'h55); rd(v); chk("read_ar20", v, 0);
        wr(15, 'hC3); rd(v); chk("read_r15", v, 'hC3);
        repeat (3) @(negedge clk);
        chk("read_hold", int'(pdata_out), 'hC3);

        // Reset in the middle of a frame.
        prog(base);
        run(0, 100);
        char_en = 1'b1; proc_en = 1'b1; ncs = 1'b0; rnw = 1'b1; a0 = 1'b1;
        nres = 1'b0;
        @(negedge clk);
        chk("midframe_reset", int'({pdata_out, ma, ra, hsync, vsync, disen, cursor}), 0);
        proc_en = 1'b0; ncs = 1'b1; rnw = 1'b0; a0 = 1'b0;
        nres = 1'b1;
        run(0, 64);

        // Blink modes on a small 64-character frame.
        do_reset();
        cfg = '{7, 6, 6, 'h11, 1, 0, 2, 1, 0, 3, 'h42, 3, 0, 0, 0, 5};
        prog(cfg);
        run(0, 26 * 64);
        chk("blink_frame0", tsum(S_CU, 0, 64), 0);
        chk("blink_frame8", tsum(S_CU, 8 * 64, 64), 2);
        chk("blink_frame15", tsum(S_CU, 15 * 64, 64), 2);
        chk("blink_frame16", tsum(S_CU, 16 * 64, 64), 0);
        chk("blink_frame24", tsum(S_CU, 24 * 64, 64), 2);
        wr(10, 'h22);
        run(0, 20 * 64);
        chk("blink_off", tsum(S_CU, 0, 20 * 64), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/crtc_6845.md
# crtc_6845

Character-based CRT controller: the timing master that feeds the video ULA. It generates the horizontal and vertical character/scanline counters, memory address (MA) and row address (RA) for video RAM fetches, HSYNC/VSYNC, and the DISEN and CURSOR qualifiers that the ULA consumes alongside each fetched pixel byte. A CPU-side register file, a subset of the MC6845, programs all geometry.

## Interface
- No parameters.
- PIXELCLK  in  1  system clock; all state changes on rising edge.
- nRESET  in  1  synchronous, active-low reset.
- CHAR_EN  in  1  one-cycle pulse per character time (from ULA clock divider); counters advance only when 1.
- PROC_EN  in  1  one-cycle CPU bus strobe; register access only when 1.
- nCS  in  1  chip select, active low.
- RnW  in  1  1 = read, 0 = write.
- A0  in  1  0 = address register, 1 = data register.
- pDATA  in  8  CPU write data.
- pDATA_out  out  8  CPU read data (registered).
- MA  out  14  video memory character address.
- RA  out  5  scanline within character row.
- HSYNC, VSYNC  out  1  sync pulses, active high.
- DISEN  out  1  display enable to ULA.
- CURSOR  out  1  cursor qualifier to ULA.

## Operation
- Registers (masked on write): R0 H total [7:0]; R1 H displayed [7:0]; R2 HSYNC position [7:0]; R3 widths, [3:0] H, [7:4] V; R4 V total [6:0]; R5 V adjust [4:0]; R6 V displayed [6:0]; R7 VSYNC position [6:0]; R8 ignored; R9 max scanline [4:0]; R10 cursor start [6:0] ([6:5] blink mode, [4:0] line); R11 cursor end [4:0]; R12/R13 start address hi [5:0]/lo [7:0]; R14/R15 cursor address hi [5:0]/lo [7:0].
- Write (PROC_EN & ~nCS & ~RnW): A0=0 loads AR <= pDATA[4:0]; A0=1 loads R[AR] if AR<16, else discarded.
- Read (PROC_EN & ~nCS & RnW & A0): pDATA_out <= R14 or R15 when AR=14/15, else 0x00. Otherwise pDATA_out holds.
- Horizontal counter hc: 0..R0, wraps to 0 after R0 (end of line).
- Scanline counter ra: increments at end of line; after R9, wraps to 0 and row counter vc increments.
- vc counts 0..R4. After row R4 completes, enter adjust: R5 extra scanlines (R5=0: none), ra counting from 0. Then frame end: vc=0, ra=0, frame counter fc (5 bit) increments mod 32.
- Line address: at frame end, ma_row <= {R12,R13}. At end of line with ra==R9 (not in adjust), ma_row <= ma_row + R1. All MA arithmetic mod 2^14.
- HSYNC: starts at hc==R2 and lasts R3[3:0] characters; width 0 produces no pulse.
- VSYNC: starts at the first scanline of row R7 and lasts R3[7:4] scanlines; width 0 means 16. A pulse runs to completion across frame end.
- DISEN = (hc < R1) & (vc < R6) & not in adjust.
- Cursor: (ma_row+hc)=={R14,R15} & R10[4:0] <= ra <= R11[4:0] & DISEN & blink. Blink by R10[6:5]: 00 on, 01 off, 10 fc[3], 11 fc[4].
- Registers are sampled live; mid-frame writes take effect at the next comparison, with no retiming. If hc > R0 after a write, hc counts up, wraps mod 256, then hits R0.

## Timing
- Reset (nRESET=0 at an edge): all registers, AR, hc, ra, vc, fc, ma_row, and every output are 0. Reset overrides CHAR_EN and PROC_EN.
- On a CHAR_EN edge: outputs <= decode(current hc/ra/vc/ma_row), counters <= next. Outputs therefore lag counter state by exactly one character; the ULA absorbs this.
- Between CHAR_EN pulses, all outputs and counters hold.
- Register writes complete on the PROC_EN edge. A write on the same edge as CHAR_EN takes effect at the next CHAR_EN.
- Read data is valid the cycle after the PROC_EN edge.

## Test plan
- Reset, then CHAR_EN held high: all outputs 0 at every edge. With all registers 0, every character is a line end and DISEN stays 0.
- Program R0=63, R1=40, R2=49, R3=0x24, R4=2, R5=0, R6=2, R7=1, R9=7, R12/R13=0x0000, CHAR_EN every cycle:
  - DISEN is high for 40 chars per line, only on rows 0-1.
  - HSYNC is high for 4 chars, 50 edges after line start.
  - VSYNC is high for 2 lines starting at row 1, ra 0.
  - Frame is 24 lines × 64 chars.
- Same setup: MA sequence is row 0 = 0..39 (8 lines), row 1 = 40..79. With R12/R13=0x3FF0, MA wraps 0x3FFF -> 0x0000.
- R5=3: three adjust scanlines follow row 2, with DISEN=0 and RA=0,1,2, before frame restart.
- R14/R15=0x0005, R10=0x02, R11=0x03: CURSOR is high only at MA=5, RA 2-3. With R10[6:5]=10, CURSOR alternates on/off every 8 frames. With 01, it never asserts.
- Write AR=14, then data 0x3A (masked to 0x3A), then read with A0=1: pDATA_out=0x3A. With AR=20, a write is ignored and a read returns 0x00. Asserting nRESET mid-frame returns all outputs to 0 at the next edge.
